// File: rtl/tdm_mux_pkg.sv
// Shared definitions for the 14-channel TDM gatherer: channel count,
// tag width, frame states and the header word constants.
package tdm_mux_pkg;

  localparam int NUM_CH = 14;
  localparam int SEL_W  = 4;

  localparam logic [3:0]       HDR_TAG = 4'hA;
  localparam logic [SEL_W-1:0] HDR_SEL = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    SCAN,
    DONE
  } state_t;

  // Number of enabled channels in a mask; at most 14, so it fits the tag width.
  function automatic logic [SEL_W-1:0] popcount(input logic [NUM_CH-1:0] m);
    logic [SEL_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      c = c + SEL_W'(m[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/next_chan_finder.sv
// Combinational priority encoder: finds the next set mask bit strictly
// above idx, or the lowest set bit when none is asserted (no current index).
module next_chan_finder
  import tdm_mux_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [SEL_W-1:0]  idx,
  input  logic              none,
  output logic [SEL_W-1:0]  nextIdx,
  output logic              found
);

  // Walk from the top down so the lowest qualifying bit is the one that sticks.
  always_comb begin
    nextIdx = '0;
    found   = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i] && (none || (i > int'(idx)))) begin
        nextIdx = SEL_W'(i);
        found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tdm_mux14to1.sv
// 14-to-1 time-division multiplexer. A Start in IDLE snapshots all channel
// inputs and the enable mask, then the enabled channels are streamed in
// ascending order under a valid/ready handshake, each tagged with its index.
// Optional build macro TDM_MUX_HEADER_EN prepends a header word
// {4'hA, channel count} tagged 4'hF to every frame.
module tdm_mux14to1
  import tdm_mux_pkg::*;
#(
  parameter int DATA_W = 8
)(
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] In0,
  input  logic [DATA_W-1:0] In1,
  input  logic [DATA_W-1:0] In2,
  input  logic [DATA_W-1:0] In3,
  input  logic [DATA_W-1:0] In4,
  input  logic [DATA_W-1:0] In5,
  input  logic [DATA_W-1:0] In6,
  input  logic [DATA_W-1:0] In7,
  input  logic [DATA_W-1:0] In8,
  input  logic [DATA_W-1:0] In9,
  input  logic [DATA_W-1:0] In10,
  input  logic [DATA_W-1:0] In11,
  input  logic [DATA_W-1:0] In12,
  input  logic [DATA_W-1:0] In13,
  input  logic [13:0]       ChanMask,
  input  logic              Start,
  output logic [DATA_W-1:0] Out,
  output logic [3:0]        OutSel,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              Busy,
  output logic              FrameDone
);

  logic [DATA_W-1:0] inArr    [NUM_CH];
  logic [DATA_W-1:0] snapData [NUM_CH];
  logic [NUM_CH-1:0] snapMask;
  state_t            state;
  logic [SEL_W-1:0]  idx;
  logic [DATA_W-1:0] outReg;
  logic [SEL_W-1:0]  outSelReg;
  logic              outValidReg;
  logic              frameDoneReg;

  logic [NUM_CH-1:0] findMask;
  logic              findNone;
  logic [SEL_W-1:0]  nextIdx;
  logic              found;

  assign inArr[0]  = In0;
  assign inArr[1]  = In1;
  assign inArr[2]  = In2;
  assign inArr[3]  = In3;
  assign inArr[4]  = In4;
  assign inArr[5]  = In5;
  assign inArr[6]  = In6;
  assign inArr[7]  = In7;
  assign inArr[8]  = In8;
  assign inArr[9]  = In9;
  assign inArr[10] = In10;
  assign inArr[11] = In11;
  assign inArr[12] = In12;
  assign inArr[13] = In13;

  // In IDLE the first channel comes from the live mask, since the snapshot is
  // being loaded on that same edge; afterwards only the snapshot is consulted.
  assign findMask = (state == IDLE) ? ChanMask : snapMask;
  assign findNone = (state != SCAN);

  next_chan_finder u_finder (
    .mask    (findMask),
    .idx     (idx),
    .none    (findNone),
    .nextIdx (nextIdx),
    .found   (found)
  );

  assign Out       = outReg;
  assign OutSel    = outSelReg;
  assign OutValid  = outValidReg;
  assign FrameDone = frameDoneReg;
  assign Busy      = (state != IDLE);

  // Frame FSM; every output word is loaded one edge ahead so outputs stay registered.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state        <= IDLE;
      idx          <= '0;
      snapMask     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        snapData[i] <= '0;
      end
      outReg       <= '0;
      outSelReg    <= '0;
      outValidReg  <= 1'b0;
      frameDoneReg <= 1'b0;
    end else begin
      frameDoneReg <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            for (int i = 0; i < NUM_CH; i++) begin
              snapData[i] <= inArr[i];
            end
            snapMask <= ChanMask;
`ifdef TDM_MUX_HEADER_EN
            state       <= HDR;
            outReg      <= DATA_W'({HDR_TAG, popcount(ChanMask)});
            outSelReg   <= HDR_SEL;
            outValidReg <= 1'b1;
`else
            if (found) begin
              state       <= SCAN;
              idx         <= nextIdx;
              outReg      <= inArr[nextIdx];
              outSelReg   <= nextIdx;
              outValidReg <= 1'b1;
            end else begin
              state        <= DONE;
              frameDoneReg <= 1'b1;
            end
`endif
          end
        end
`ifdef TDM_MUX_HEADER_EN
        HDR: begin
          if (OutReady) begin
            if (found) begin
              state     <= SCAN;
              idx       <= nextIdx;
              outReg    <= snapData[nextIdx];
              outSelReg <= nextIdx;
            end else begin
              state        <= DONE;
              outValidReg  <= 1'b0;
              frameDoneReg <= 1'b1;
            end
          end
        end
`endif
        SCAN: begin
          if (OutReady) begin
            if (found) begin
              idx       <= nextIdx;
              outReg    <= snapData[nextIdx];
              outSelReg <= nextIdx;
            end else begin
              state        <= DONE;
              outValidReg  <= 1'b0;
              frameDoneReg <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
